pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
Parametrised, pipelined add/subtract unit: the next generation of the team's simple combinational adder. It accepts operand pairs through a valid/ready handshake and returns results after a fixed pipeline latency. It supports full backpressure and reports carry/borrow and signed overflow. It also keeps a count of completed results, and sits between stimulus-side logic and any result consumer in the datapath.

Parameters:
Width, 8, operand and result width in bits (legal 2..64)
Stages, 2, pipeline depth in register stages (legal 1..4)
CntWidth, 16, width of completed-result counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair this cycle
sub  input  1  mode: 0 = A+B, 1 = A-B; sampled with operands
A  input  Width  operand A (unsigned, or two's complement for overflow flag)
B  input  Width  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
C  output  Width  result
co  output  1  carry-out (add) or borrow (sub)
ovf  output  1  signed two's-complement overflow
done_cnt  output  CntWidth  number of results accepted by the consumer

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low on rst. Assertion clears immediately, independent of clk.
- Reset values: in_ready=1 once reset has been released (0 while rst low), out_valid=0, C=0, co=0, ovf=0, done_cnt=0. All stage valid bits are cleared.
- Input transfer occurs when in_valid && in_ready at a rising clk. Output transfer occurs when out_valid && out_ready.
- Pipeline: Stages registered stages, each holding {valid, C, co, ovf}. Arithmetic is computed combinationally before stage 0. Later stages are pure registers.
- Per-stage advance: stage i loads when ready_i = !valid_i || ready_{i+1}. The last stage's downstream ready is out_ready. in_ready = ready_0 (combinational from out_ready, no skid buffer).
- Latency: a result is presented on out_valid exactly Stages cycles after input transfer, provided there is no backpressure.
- Throughput: 1 transfer per cycle sustained while out_ready=1.
- Backpressure: while out_valid && !out_ready, C/co/ovf/out_valid hold stable. Bubbles compress, so upstream stages with valid=0 still load. No data is dropped or duplicated, and order is preserved.
- Add arithmetic: {co,C} = A + B (Width+1 bits).
- Sub arithmetic: C = (A - B) mod 2^Width, and co = 1 iff A < B unsigned.
- ovf (add): operands have the same sign and the result sign differs.
- ovf (sub): operands have different signs and the result sign differs from A.
- done_cnt increments by 1 on each output transfer and wraps to 0 after 2^CntWidth-1. It does not saturate.
- Mode and operands are captured per transaction. Changing sub while the pipeline is occupied does not affect in-flight results.
- Reset mid-operation: all in-flight results are discarded, and no out_valid pulse follows reset release.
- in_valid is ignored while in_ready=0. The upstream source must hold A/B/sub stable until transfer.

Optional Feature:
Macro: PIPE_ADDER_SAT_EN
- Defined: unsigned saturation is applied before stage 0.
  - add with co=1 gives C = all ones.
  - sub with co=1 (borrow) gives C = 0.
  - co and ovf are still reported unchanged.
- Undefined: C wraps modulo 2^Width as specified in Behaviour.
- Only C differs between the two builds.

Test Plan:
- Reset, then single add (Width=8, Stages=2): A=0x05, B=0x03, sub=0, out_ready=1. Expect out_valid exactly 2 cycles after transfer, C=0x08, co=0, ovf=0, done_cnt=1.
- Wrap/flags: A=0xFF, B=0x01 add gives C=0x00, co=1, ovf=0. A=0x7F, B=0x01 add gives C=0x80, co=0, ovf=1. A=0x03, B=0x05 sub gives C=0xFE, co=1, ovf=0. With PIPE_ADDER_SAT_EN: C=0xFF, 0x80, 0x00 respectively.
- Backpressure: stream 6 back-to-back pairs (i, i+1), i=0..5, with out_ready held 0 for cycles 3..7. Expect in_ready=0 once both stages are full, C stable while stalled, then in-order results 1,3,5,7,9,11 with no loss, and done_cnt=6.
- Streaming throughput: 100 random pairs with in_valid=1 and out_ready=1 continuously. Expect one out_valid per cycle after a Stages-cycle fill, and every result matching the reference model.
- Asynchronous reset mid-flight: assert rst low between clock edges with 2 results in flight. Expect out_valid=0 and done_cnt=0 immediately, and no stale result after release.
- Counter wrap (CntWidth=4): complete 17 transfers. Expect done_cnt sequence …,15,0,1.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready handshake, carry/borrow, overflow and result counter.
// Optional build macro PIPE_ADDER_SAT_EN enables unsigned saturation of C.
module pipe_adder #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Stages   = 2,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [Width-1:0]    A,
  input  logic [Width-1:0]    B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Width-1:0]    C,
  output logic                co,
  output logic                ovf,
  output logic [CntWidth-1:0] done_cnt
);

  logic [Width:0]                  w_sum;
  logic [Width-1:0]                w_c;
  logic                            w_co;
  logic                            w_ovf;
  logic [Stages-1:0]               w_ready;

  logic [Stages-1:0]               r_vld;
  logic [Stages-1:0][Width-1:0]    r_c;
  logic [Stages-1:0]               r_co;
  logic [Stages-1:0]               r_ovf;
  logic [CntWidth-1:0]             r_cnt;

  // Extra MSB of the difference is the borrow, i.e. set iff A < B unsigned.
  always_comb begin
    if (sub) begin
      w_sum = {1'b0, A} - {1'b0, B};
      w_ovf = (A[Width-1] != B[Width-1]) && (w_sum[Width-1] != A[Width-1]);
    end else begin
      w_sum = {1'b0, A} + {1'b0, B};
      w_ovf = (A[Width-1] == B[Width-1]) && (w_sum[Width-1] != A[Width-1]);
    end
    w_co = w_sum[Width];
`ifdef PIPE_ADDER_SAT_EN
    if (w_co) begin
      w_c = sub ? '0 : '1;
    end else begin
      w_c = w_sum[Width-1:0];
    end
`else
    w_c = w_sum[Width-1:0];
`endif
  end

  // A stage is ready if it or any stage downstream holds a bubble, or the consumer takes data.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < Stages; i++) begin
      w_ready[i] = out_ready;
      for (int j = i; j < Stages; j++) begin
        if (!r_vld[j]) begin
          w_ready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_c   <= '0;
      r_co  <= '0;
      r_ovf <= '0;
    end else begin
      if (w_ready[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_c[0]   <= w_c;
          r_co[0]  <= w_co;
          r_ovf[0] <= w_ovf;
        end
      end
      for (int i = 1; i < Stages; i++) begin
        if (w_ready[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_c[i]   <= r_c[i-1];
            r_co[i]  <= r_co[i-1];
            r_ovf[i] <= r_ovf[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = rst & w_ready[0];
  assign out_valid = r_vld[Stages-1];
  assign C         = r_c[Stages-1];
  assign co        = r_co[Stages-1];
  assign ovf       = r_ovf[Stages-1];
  assign done_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed flag cases, backpressure, streaming, async reset,
// counter wrap; expected results come from an integer-arithmetic reference queue.
module tb_pipe_adder;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 4;

  typedef struct {
    int c;
    int co;
    int ovf;
    int tx;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sub = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  C;
  logic          co;
  logic          ovf;
  logic [CW-1:0] done_cnt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   stall_total = 0;
  bit   lat_chk = 0;
  bit   prev_stall = 0;
  bit   saw_not_ready = 0;
  int   prev_out = 0;
  res_t q[$];

  pipe_adder #(
    .Width   (W),
    .Stages  (S),
    .CntWidth(CW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .C        (C),
    .co       (co),
    .ovf      (ovf),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t ref_model(input int a, input int b, input bit s, input int t);
    res_t r;
    int   m;
    int   sa;
    int   sb;
    int   sr;
    m  = 1 << W;
    r.tx = t;
    if (s) begin
      r.c  = ((a - b) % m + m) % m;
      r.co = (a < b) ? 1 : 0;
    end else begin
      r.c  = (a + b) % m;
      r.co = (a + b >= m) ? 1 : 0;
    end
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = s ? sa - sb : sa + sb;
    r.ovf = (sr >= m / 2 || sr < -(m / 2)) ? 1 : 0;
`ifdef PIPE_ADDER_SAT_EN
    if (r.co == 1) r.c = s ? 0 : m - 1;
`endif
    return r;
  endfunction

  // Monitor: sample mid-cycle, the values that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      res_t e;
      check_eq("done_cnt", done_cnt, exp_cnt % (1 << CW));
      if (!in_ready) saw_not_ready = 1;
      if (prev_stall && out_valid) check_eq("stall_hold", {C, co, ovf}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = {C, co, ovf};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("out_spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          check_eq("C", C, e.c);
          check_eq("co", co, e.co);
          check_eq("ovf", ovf, e.ovf);
          if (lat_chk) check_eq("latency", cyc - e.tx, S);
          exp_cnt++;
        end
      end
      if (in_valid && in_ready) q.push_back(ref_model(A, B, sub, cyc));
    end
  end

  task automatic clear_model();
    q.delete();
    exp_cnt    = 0;
    prev_stall = 0;
  endtask

  task automatic do_reset();
    in_valid  = 0;
    out_ready = 1;
    rst       = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_C", C, 0);
    check_eq("rst_flags", {co, ovf}, 0);
    check_eq("rst_done_cnt", done_cnt, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check_eq("rel_in_ready", in_ready, 1);
  endtask

  // Call at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    A = a;
    B = b;
    sub = s;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    stall_total += n;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int ec, input int eco, input int eovf, input string tag);
    int n;
    send(a, b, s);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_C"}, C, ec);
    check_eq({tag, "_co"}, co, eco);
    check_eq({tag, "_ovf"}, ovf, eovf);
    drain();
  endtask

  initial begin
    // Single add and flag cases
    do_reset();
    lat_chk = 1;
    directed(8'h05, 8'h03, 1'b0, 8'h08, 0, 0, "add5_3");
    check_eq("single_done_cnt", done_cnt, 1);
`ifdef PIPE_ADDER_SAT_EN
    directed(8'hFF, 8'h01, 1'b0, 8'hFF, 1, 0, "addFF_1");
    directed(8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, "add7F_1");
    directed(8'h03, 8'h05, 1'b1, 8'h00, 1, 0, "sub3_5");
`else
    directed(8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, "addFF_1");
    directed(8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, "add7F_1");
    directed(8'h03, 8'h05, 1'b1, 8'hFE, 1, 0, "sub3_5");
`endif
    directed(8'h80, 8'h01, 1'b1, 8'h7F, 0, 1, "sub80_1");

    // Backpressure
    do_reset();
    lat_chk = 0;
    saw_not_ready = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'(i), W'(i + 1), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check_eq("bp_in_ready_low", saw_not_ready, 1);
    check_eq("bp_done_cnt", done_cnt, 6);

    // Streaming throughput
    do_reset();
    lat_chk = 1;
    stall_total = 0;
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    check_eq("stream_stalls", stall_total, 0);
    check_eq("stream_done_cnt", done_cnt, 100 % (1 << CW));

    // Async reset with two results in flight
    do_reset();
    send(8'h11, 8'h22, 1'b0);
    drain();
    send(8'h01, 8'h02, 1'b0);
    send(8'h03, 8'h04, 1'b1);
    #2;
    rst = 0;
    clear_model();
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_done_cnt", done_cnt, 0);
    check_eq("arst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("arst_no_stale", out_valid, 0);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    check_eq("wrap_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
